// File: rtl/wb_burst_master.sv
// ============================================================================
//  Module   : wb_burst_master
//  Purpose  : Wishbone initiator that issues incrementing-burst writes of a
//             seed+k pattern and reads ranges back, counting mismatches.
//             Optional ack watchdog: define WB_BURST_MASTER_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_burst_master #(
    parameter int APP_AW      = 26,
    parameter int dw          = 32,
    parameter int bl          = 9,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [APP_AW-1:0] cmd_addr_i,
    input  logic [bl-1:0]     cmd_len_i,
    input  logic [dw-1:0]     cmd_seed_i,
    input  logic              err_clr_i,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [APP_AW-1:0] wb_addr_o,
    output logic [dw-1:0]     wb_dat_o,
    output logic [dw/8-1:0]   wb_sel_o,
    output logic [2:0]        wb_cti_o,
    input  logic              wb_ack_i,
    input  logic [dw-1:0]     wb_dat_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [15:0]       err_cnt_o,
    output logic [APP_AW-1:0] first_err_addr_o,
    output logic              timeout_o
);

    localparam logic [2:0] c_CTI_INCR = 3'b010;
    localparam logic [2:0] c_CTI_END  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_we,   w_we_nxt;
    logic [bl-1:0]     r_len,  w_len_nxt;
    logic [bl-1:0]     r_idx,  w_idx_nxt;
    logic [dw-1:0]     r_pat,  w_pat_nxt;
    logic [APP_AW-1:0] r_addr, w_addr_nxt;
    logic [dw-1:0]     r_dat,  w_dat_nxt;
    logic              r_cyc,  w_cyc_nxt;
    logic [2:0]        r_cti,  w_cti_nxt;
    logic              r_ready;
    logic              r_busy;
    logic              r_done;
    logic [15:0]       r_err_cnt;
    logic [APP_AW-1:0] r_first_err;

    logic              w_ack;
    logic              w_last;
    logic [bl-1:0]     w_idx_inc;
    logic [dw-1:0]     w_pat_inc;
    logic              w_mis;
    logic              w_expire;

    assign w_ack     = r_cyc & wb_ack_i;
    assign w_last    = (r_idx == r_len - bl'(1));
    assign w_idx_inc = r_idx + bl'(1);
    assign w_pat_inc = r_pat + dw'(1);
    assign w_mis     = w_ack & ~r_we & (wb_dat_i != r_pat);

    always_comb begin
        w_state_nxt = r_state;
        w_we_nxt    = r_we;
        w_len_nxt   = r_len;
        w_idx_nxt   = r_idx;
        w_pat_nxt   = r_pat;
        w_addr_nxt  = r_addr;
        w_dat_nxt   = r_dat;
        w_cyc_nxt   = r_cyc;
        w_cti_nxt   = r_cti;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    w_we_nxt   = cmd_we_i;
                    w_len_nxt  = cmd_len_i;
                    w_idx_nxt  = '0;
                    w_pat_nxt  = cmd_seed_i;
                    w_addr_nxt = cmd_addr_i;
                    if (cmd_len_i == '0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_REQ;
                        w_cyc_nxt   = 1'b1;
                        w_dat_nxt   = cmd_we_i ? cmd_seed_i : '0;
                        w_cti_nxt   = (cmd_len_i == bl'(1)) ? c_CTI_END : c_CTI_INCR;
                    end
                end
            end
            S_REQ: begin
                if (w_ack) begin
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                        w_cyc_nxt   = 1'b0;
                        w_dat_nxt   = '0;
                        w_cti_nxt   = 3'b000;
                    end else begin
                        // Advance to the next beat at the same edge that took the ack
                        w_idx_nxt  = w_idx_inc;
                        w_addr_nxt = r_addr + APP_AW'(4);
                        w_pat_nxt  = w_pat_inc;
                        w_dat_nxt  = r_we ? w_pat_inc : '0;
                        w_cti_nxt  = (w_idx_inc == r_len - bl'(1)) ? c_CTI_END : c_CTI_INCR;
                    end
                end else if (w_expire) begin
                    w_state_nxt = S_DONE;
                    w_cyc_nxt   = 1'b0;
                    w_dat_nxt   = '0;
                    w_cti_nxt   = 3'b000;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cyc_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_len   <= '0;
            r_idx   <= '0;
            r_pat   <= '0;
            r_addr  <= '0;
            r_dat   <= '0;
            r_cyc   <= 1'b0;
            r_cti   <= 3'b000;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_we    <= w_we_nxt;
            r_len   <= w_len_nxt;
            r_idx   <= w_idx_nxt;
            r_pat   <= w_pat_nxt;
            r_addr  <= w_addr_nxt;
            r_dat   <= w_dat_nxt;
            r_cyc   <= w_cyc_nxt;
            r_cti   <= w_cti_nxt;
            r_ready <= (w_state_nxt == S_IDLE);
            r_busy  <= (w_state_nxt == S_REQ);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    // A clear coinciding with a mismatch restarts the record at this beat
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_err_cnt   <= '0;
            r_first_err <= '0;
        end else if (w_mis) begin
            if (err_clr_i) begin
                r_err_cnt   <= 16'd1;
                r_first_err <= r_addr;
            end else begin
                if (r_err_cnt == '0) begin
                    r_first_err <= r_addr;
                end
                if (r_err_cnt != 16'hFFFF) begin
                    r_err_cnt <= r_err_cnt + 16'd1;
                end
            end
        end else if (err_clr_i) begin
            r_err_cnt   <= '0;
            r_first_err <= '0;
        end
    end

`ifdef WB_BURST_MASTER_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYC - 1);

    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_timeout;

    // Expires on the TIMEOUT_CYC-th consecutive REQ cycle without ack
    assign w_expire = (r_state == S_REQ) && !wb_ack_i && (r_to_cnt == c_TO_LAST);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if ((r_state != S_REQ) || wb_ack_i) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + c_TO_W'(1);
            end
            if (w_expire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout_o = r_timeout;
`else
    assign w_expire  = 1'b0;
    assign timeout_o = 1'b0;
`endif

    assign cmd_ready_o      = r_ready;
    assign busy_o           = r_busy;
    assign done_o           = r_done;
    assign wb_cyc_o         = r_cyc;
    assign wb_stb_o         = r_cyc;
    assign wb_we_o          = r_we & r_cyc;
    assign wb_addr_o        = r_addr;
    assign wb_dat_o         = r_dat;
    assign wb_sel_o         = '1;
    assign wb_cti_o         = r_cti;
    assign err_cnt_o        = r_err_cnt;
    assign first_err_addr_o = r_first_err;

endmodule

`default_nettype wire

// File: tb/tb_wb_burst_master.sv
// ============================================================================
//  Module   : tb_wb_burst_master
//  Purpose  : Self-checking bench for wb_burst_master with a scoreboarded
//             Wishbone slave model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_burst_master;

    localparam int AW = 26;
    localparam int DW = 32;
    localparam int BL = 9;

    logic          clk = 1'b0;
    logic          wb_rst_i = 1'b1;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic          cmd_we_i = 1'b0;
    logic [AW-1:0] cmd_addr_i = '0;
    logic [BL-1:0] cmd_len_i = '0;
    logic [DW-1:0] cmd_seed_i = '0;
    logic          err_clr_i = 1'b0;
    logic          wb_cyc_o, wb_stb_o, wb_we_o;
    logic [AW-1:0] wb_addr_o;
    logic [DW-1:0] wb_dat_o;
    logic [DW/8-1:0] wb_sel_o;
    logic [2:0]    wb_cti_o;
    logic          wb_ack_i = 1'b0;
    logic [DW-1:0] wb_dat_i = '0;
    logic          busy_o, done_o, timeout_o;
    logic [15:0]   err_cnt_o;
    logic [AW-1:0] first_err_addr_o;

    always #5 clk = ~clk;

    wb_burst_master dut (
        .wb_clk_i         (clk),
        .wb_rst_i         (wb_rst_i),
        .cmd_valid_i      (cmd_valid_i),
        .cmd_ready_o      (cmd_ready_o),
        .cmd_we_i         (cmd_we_i),
        .cmd_addr_i       (cmd_addr_i),
        .cmd_len_i        (cmd_len_i),
        .cmd_seed_i       (cmd_seed_i),
        .err_clr_i        (err_clr_i),
        .wb_cyc_o         (wb_cyc_o),
        .wb_stb_o         (wb_stb_o),
        .wb_we_o          (wb_we_o),
        .wb_addr_o        (wb_addr_o),
        .wb_dat_o         (wb_dat_o),
        .wb_sel_o         (wb_sel_o),
        .wb_cti_o         (wb_cti_o),
        .wb_ack_i         (wb_ack_i),
        .wb_dat_i         (wb_dat_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .err_cnt_o        (err_cnt_o),
        .first_err_addr_o (first_err_addr_o),
        .timeout_o        (timeout_o)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdat;
        logic [DW-1:0] rdat;
        logic [2:0]    cti;
        logic          we;
        logic          clr;
    } beat_t;

    beat_t q[$];
    beat_t e_cur;

    int n_cmp = 0;
    int n_bad = 0;
    int dn_cnt = 0;
    int beat_cnt = 0;
    int stb_cyc = 0;
    int wait_cfg = 0;
    int wait_ctr = 0;
    bit hang = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave model: acks after wait_cfg idle cycles, checks each beat against the scoreboard
    always @(negedge clk) begin
        wb_ack_i  = 1'b0;
        err_clr_i = 1'b0;
        if (done_o) dn_cnt++;
        if (wb_stb_o) stb_cyc++;
        if (wb_rst_i) begin
            wait_ctr = 0;
        end else if (wb_stb_o && !hang) begin
            if (wait_ctr >= wait_cfg) begin
                wait_ctr = 0;
                wb_ack_i = 1'b1;
                beat_cnt++;
                if (q.size() == 0) begin
                    check("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    e_cur = q.pop_front();
                    check("beat_addr", 64'(wb_addr_o), 64'(e_cur.addr));
                    check("beat_wdat", 64'(wb_dat_o), 64'(e_cur.wdat));
                    check("beat_cti", 64'(wb_cti_o), 64'(e_cur.cti));
                    check("beat_we", 64'(wb_we_o), 64'(e_cur.we));
                    check("beat_sel", 64'(wb_sel_o), 64'hF);
                    wb_dat_i  = e_cur.rdat;
                    err_clr_i = e_cur.clr;
                end
            end else begin
                wait_ctr++;
            end
        end
    end

    task automatic issue_cmd(input logic we, input logic [AW-1:0] addr, input int len,
                             input logic [DW-1:0] seed, input int corrupt, input int clr_at);
        beat_t b;
        logic [DW-1:0] pat;
        for (int k = 0; k < len; k++) begin
            pat    = seed + DW'(k);
            b.addr = addr + AW'(4 * k);
            b.wdat = we ? pat : '0;
            b.rdat = (k == corrupt) ? (pat ^ 32'h0000_0100) : pat;
            b.cti  = (k == len - 1) ? 3'b111 : 3'b010;
            b.we   = we;
            b.clr  = (k == clr_at);
            q.push_back(b);
        end
        @(negedge clk);
        check("ready_idle", 64'(cmd_ready_o), 64'd1);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_addr_i  = addr;
        cmd_len_i   = BL'(len);
        cmd_seed_i  = seed;
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
        check("cyc_start", 64'(wb_cyc_o), (len != 0) ? 64'd1 : 64'd0);
        if (len == 0) check("done_len0", 64'(done_o), 64'd1);
    endtask

    task automatic run_cmd(input logic we, input logic [AW-1:0] addr, input int len,
                           input logic [DW-1:0] seed, input int corrupt, input int clr_at);
        int d0;
        bit got;
        d0  = dn_cnt;
        got = 1'b0;
        issue_cmd(we, addr, len, seed, corrupt, clr_at);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (done_o) begin
                got = 1'b1;
                break;
            end
        end
        check("done_seen", 64'(got), 64'd1);
        @(negedge clk);
        check("ready_after", 64'(cmd_ready_o), 64'd1);
        check("cyc_after", 64'(wb_cyc_o), 64'd0);
        check("done_once", 64'(dn_cnt - d0), 64'd1);
        check("sb_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int d0;
        int b0;
        bit got;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(cmd_ready_o), 64'd1);
        check("rst_cyc", 64'(wb_cyc_o), 64'd0);
        check("rst_sel", 64'(wb_sel_o), 64'hF);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_err", 64'(err_cnt_o), 64'd0);
        check("rst_cti", 64'(wb_cti_o), 64'd0);
        wb_rst_i = 1'b0;

        run_cmd(1'b1, 26'h100, 8, 32'hA5A5_0000, -1, -1);
        run_cmd(1'b0, 26'h100, 8, 32'hA5A5_0000, -1, -1);
        check("err_clean", 64'(err_cnt_o), 64'd0);
        run_cmd(1'b0, 26'h100, 8, 32'hA5A5_0000, 3, -1);
        check("err_b3_cnt", 64'(err_cnt_o), 64'd1);
        check("err_b3_addr", 64'(first_err_addr_o), 64'h10C);
        run_cmd(1'b0, 26'h100, 8, 32'hA5A5_0000, 6, -1);
        check("err_2nd_cnt", 64'(err_cnt_o), 64'd2);
        check("err_2nd_addr", 64'(first_err_addr_o), 64'h10C);
        run_cmd(1'b0, 26'h100, 8, 32'hA5A5_0000, -1, 7);
        check("clr_cnt", 64'(err_cnt_o), 64'd0);
        check("clr_addr", 64'(first_err_addr_o), 64'd0);
        run_cmd(1'b0, 26'h100, 8, 32'hA5A5_0000, 0, -1);
        check("err_b0_addr", 64'(first_err_addr_o), 64'h100);
        run_cmd(1'b0, 26'h100, 8, 32'hA5A5_0000, 5, 5);
        check("clrmis_cnt", 64'(err_cnt_o), 64'd1);
        check("clrmis_addr", 64'(first_err_addr_o), 64'h114);

        run_cmd(1'b1, 26'h200, 1, 32'h1234_5678, -1, -1);
        run_cmd(1'b1, 26'h300, 0, 32'h0, -1, -1);
        run_cmd(1'b1, 26'h3FF_FFFC, 2, 32'hFFFF_FFFF, -1, -1);
        run_cmd(1'b0, 26'h3FF_FFFC, 2, 32'hFFFF_FFFF, 1, -1);
        check("wrap_err_cnt", 64'(err_cnt_o), 64'd2);
        check("wrap_err_addr", 64'(first_err_addr_o), 64'h114);
        check("write_no_err", 64'(err_cnt_o), 64'd2);

        wait_cfg = 3;
        run_cmd(1'b1, 26'h400, 4, 32'h0BAD_F00D, -1, -1);

        // Reset while beat 2 of a 4-beat burst is outstanding
        issue_cmd(1'b1, 26'h500, 4, 32'h5555_0000, -1, -1);
        b0  = beat_cnt - 0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (beat_cnt >= b0 + 2 && !wb_ack_i) begin
                got = 1'b1;
                break;
            end
        end
        check("two_beats_seen", 64'(got), 64'd1);
        d0 = dn_cnt;
        wb_rst_i = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_cyc", 64'(wb_cyc_o), 64'd0);
        check("rst_mid_ready", 64'(cmd_ready_o), 64'd1);
        check("rst_mid_busy", 64'(busy_o), 64'd0);
        @(negedge clk);
        wb_rst_i = 1'b0;
        q.delete();
        repeat (3) @(negedge clk);
        check("rst_mid_nodone", 64'(dn_cnt - d0), 64'd0);
        check("rst_mid_err", 64'(err_cnt_o), 64'd0);
        wait_cfg = 0;
        run_cmd(1'b1, 26'h600, 3, 32'h7777_7770, -1, -1);

`ifdef WB_BURST_MASTER_TIMEOUT_EN
        hang = 1'b1;
        issue_cmd(1'b0, 26'h700, 4, 32'h0, -1, -1);
        b0  = stb_cyc;
        got = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (done_o) begin
                got = 1'b1;
                break;
            end
        end
        check("to_done", 64'(got), 64'd1);
        check("to_flag", 64'(timeout_o), 64'd1);
        check("to_cyc", 64'(wb_cyc_o), 64'd0);
        check("to_stb_cycles", 64'(stb_cyc - b0), 64'd1023);
        hang = 1'b0;
        q.delete();
        @(negedge clk);
`else
        check("to_tied", 64'(timeout_o), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
